// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the rx and tx blocks:
// default line rate, frame width and the receiver FSM state encoding.
package uart_pkg;

    localparam int CLK_FREQUENCY = 100_000_000;
    localparam int BAUD_RATE     = 19_200;
    localparam int DATA_BITS     = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP,
        ACK
    } rx_state_t;

endpackage

// File: rtl/baud_timer.sv
// Bit-period timer: after clear, pulses done once every HALF or BIT period
// and restarts itself, so consecutive bit samples stay exactly one period apart.
module baud_timer #(
    parameter int BIT_CYCLES = 5208
) (
    input  logic clk,
    input  logic Reset,
    input  logic clear,
    input  logic half,
    output logic done
);

    localparam int HALF_CYCLES = BIT_CYCLES / 2;
    localparam int CNT_W       = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_CYCLES - 1);

    logic [CNT_W-1:0] r_count;
    logic             w_expire;

    assign w_expire = (r_count == (half ? HALF_LAST : BIT_LAST));
    assign done     = w_expire && !clear;

    // Wrapping on expiry keeps the next period aligned to this sample point.
    always_ff @(posedge clk) begin
        if (Reset || clear || w_expire) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/rx.sv
// UART receiver: 8 data bits, odd parity, one stop bit, sampled at bit
// midpoints; the byte is held on Dout with Receive high until Received.
module rx #(
    parameter int CLK_FREQUENCY = uart_pkg::CLK_FREQUENCY,
    parameter int BAUD_RATE     = uart_pkg::BAUD_RATE
) (
    input  logic                          clk,
    input  logic                          Reset,
    input  logic                          Sin,
    input  logic                          Received,
    output logic                          Receive,
    output logic [uart_pkg::DATA_BITS-1:0] Dout,
    output logic                          parityErr,
    output logic                          frameErr
);

    import uart_pkg::*;

    localparam int BIT_CYCLES = CLK_FREQUENCY / BAUD_RATE;
    localparam int IDX_W      = $clog2(DATA_BITS);

    logic                 r_sync1;
    logic                 r_sin_s;
    rx_state_t            r_state;
    logic [IDX_W-1:0]     r_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_parity;
    logic [DATA_BITS-1:0] r_dout;
    logic                 r_parity_err;
    logic                 r_frame_err;
    logic                 r_receive;

    logic w_clear;
    logic w_half;
    logic w_done;

    // NOTE: both synchronizer flops reset to 1 so a reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (Reset) begin
            r_sync1 <= 1'b1;
            r_sin_s <= 1'b1;
        end else begin
            r_sync1 <= Sin;
            r_sin_s <= r_sync1;
        end
    end

    assign w_clear = (r_state == IDLE);
    assign w_half  = (r_state == START);

    baud_timer #(
        .BIT_CYCLES(BIT_CYCLES)
    ) u_timer (
        .clk  (clk),
        .Reset(Reset),
        .clear(w_clear),
        .half (w_half),
        .done (w_done)
    );

    // NOTE: every register here uses <= so all state updates see pre-edge values.
    always_ff @(posedge clk) begin
        if (Reset) begin
            r_state      <= IDLE;
            r_idx        <= '0;
            r_shift      <= '0;
            r_parity     <= 1'b0;
            r_dout       <= '0;
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
            r_receive    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (!r_sin_s) begin
                        r_state <= START;
                    end
                end
                START: begin
                    if (w_done) begin
                        if (!r_sin_s) begin
                            r_state <= DATA;
                            r_idx   <= '0;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end
                DATA: begin
                    if (w_done) begin
                        r_shift <= {r_sin_s, r_shift[DATA_BITS-1:1]};
                        if (r_idx == IDX_W'(DATA_BITS - 1)) begin
                            r_state <= PAR;
                        end else begin
                            r_idx <= r_idx + IDX_W'(1);
                        end
                    end
                end
                PAR: begin
                    if (w_done) begin
                        r_parity <= r_sin_s;
                        r_state  <= STOP;
                    end
                end
                STOP: begin
                    if (w_done) begin
                        r_dout       <= r_shift;
                        r_parity_err <= ~(^{r_shift, r_parity});
                        r_frame_err  <= ~r_sin_s;
                        r_receive    <= 1'b1;
                        r_state      <= ACK;
                    end
                end
                ACK: begin
                    if (Received) begin
                        r_receive <= 1'b0;
                        r_state   <= IDLE;
                    end
                end
                default: begin
                    r_receive <= 1'b0;
                    r_state   <= IDLE;
                end
            endcase
        end
    end

    assign Receive   = r_receive;
    assign Dout      = r_dout;
    assign parityErr = r_parity_err;
    assign frameErr  = r_frame_err;

endmodule

// File: tb/tb_rx.sv
// Directed bench for rx: a fast instance (16 clocks per bit) for the bulk of
// the cases plus one default-rate instance for a single clean byte.
`timescale 1ns/1ps
module tb_rx;

    import uart_pkg::*;

    localparam int FAST_BAUD = 6_250_000;
    localparam int BC        = CLK_FREQUENCY / FAST_BAUD;
    localparam int BCD       = CLK_FREQUENCY / BAUD_RATE;

    typedef struct {
        logic [7:0] data;
        logic       par;
        logic       stop;
        logic       exp_perr;
        logic       exp_ferr;
    } vec_t;

    logic       clk = 1'b0;
    logic       Reset;
    logic       sin, received, receive, perr, ferr;
    logic [7:0] dout;
    logic       sin_d, received_d, receive_d, perr_d, ferr_d;
    logic [7:0] dout_d;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    rx #(.CLK_FREQUENCY(CLK_FREQUENCY), .BAUD_RATE(FAST_BAUD)) dut (
        .clk      (clk),
        .Reset    (Reset),
        .Sin      (sin),
        .Received (received),
        .Receive  (receive),
        .Dout     (dout),
        .parityErr(perr),
        .frameErr (ferr)
    );

    rx dut_def (
        .clk      (clk),
        .Reset    (Reset),
        .Sin      (sin_d),
        .Received (received_d),
        .Receive  (receive_d),
        .Dout     (dout_d),
        .parityErr(perr_d),
        .frameErr (ferr_d)
    );

    // Back-to-back monitor: counts Receive rising edges and flags any pulse wider than 1 cycle.
    bit         mon_en = 1'b0;
    logic       mon_prev = 1'b0;
    int         pulses = 0;
    bit         wide = 1'b0;
    logic [7:0] cap [2];

    always @(negedge clk) begin
        if (mon_en) begin
            mon_prev <= receive;
            if (receive && !mon_prev) begin
                pulses <= pulses + 1;
                if (pulses < 2) cap[pulses] <= dout;
            end
            if (receive && mon_prev) wide <= 1'b1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_line(input bit use_def, input logic b);
        if (use_def) sin_d = b;
        else         sin   = b;
    endtask

    task automatic set_ack(input bit use_def, input logic b);
        if (use_def) received_d = b;
        else         received   = b;
    endtask

    // Called at posedge+1; returns at posedge+1 with the line back at idle.
    task automatic send_frame(input logic [7:0] d, input logic p, input logic stop,
                              input int bc, input bit use_def);
        logic [10:0] bits;
        bits = {stop, p, d, 1'b0};
        for (int i = 0; i < 11; i++) begin
            set_line(use_def, bits[i]);
            repeat (bc) @(posedge clk);
            #1;
        end
        set_line(use_def, 1'b1);
    endtask

    task automatic check_frame(input string name, input bit use_def, input int bc,
                               input logic [7:0] d, input logic pe, input logic fe);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 4 * bc; i++) begin
            @(negedge clk);
            if ((use_def ? receive_d : receive) === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        check({name, "_rise"}, 32'(ok), 32'd1);
        check({name, "_dout"}, 32'(use_def ? dout_d : dout), 32'(d));
        check({name, "_perr"}, 32'(use_def ? perr_d : perr), 32'(pe));
        check({name, "_ferr"}, 32'(use_def ? ferr_d : ferr), 32'(fe));
        @(posedge clk); #1;
        set_ack(use_def, 1'b1);
        @(posedge clk); #1;
        set_ack(use_def, 1'b0);
        @(negedge clk);
        check({name, "_fall"}, 32'(use_def ? receive_d : receive), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [6];
        bit   seen;

        // Odd parity: 9 bits (data + parity) must hold an odd number of ones.
        vecs[0] = '{8'hA5, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{8'h3C, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{8'h01, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{8'h00, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{8'hFF, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[5] = '{8'h80, 1'b0, 1'b1, 1'b0, 1'b0};

        Reset = 1'b1; sin = 1'b1; received = 1'b0; sin_d = 1'b1; received_d = 1'b0;
        repeat (4) @(posedge clk);
        #1 Reset = 1'b0;
        @(negedge clk);
        check("rst_receive", 32'(receive), 32'd0);
        check("rst_dout",    32'(dout),    32'h00);
        check("rst_perr",    32'(perr),    32'd0);
        check("rst_ferr",    32'(ferr),    32'd0);
        check("rst_state",   32'(dut.r_state), 32'(IDLE));
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++) begin
            send_frame(vecs[i].data, vecs[i].par, vecs[i].stop, BC, 1'b0);
            check_frame($sformatf("v%0d", i), 1'b0, BC, vecs[i].data, vecs[i].exp_perr, vecs[i].exp_ferr);
        end

        // Short glitch on the line: start bit rejected at its midpoint.
        sin = 1'b0;
        repeat (4) @(posedge clk);
        #1 sin = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 3 * BC; i++) begin
            @(negedge clk);
            if (receive !== 1'b0) seen = 1'b1;
        end
        check("glitch_receive", 32'(seen), 32'd0);
        check("glitch_state",   32'(dut.r_state), 32'(IDLE));
        check("glitch_dout",    32'(dout), 32'h80);
        @(posedge clk); #1;

        // Received while idle is ignored.
        received = 1'b1;
        repeat (3) @(posedge clk);
        #1 received = 1'b0;
        @(negedge clk);
        check("idle_ack_receive", 32'(receive), 32'd0);
        check("idle_ack_state",   32'(dut.r_state), 32'(IDLE));
        @(posedge clk); #1;

        // Handshake: output held while unacknowledged.
        send_frame(8'hC3, 1'b1, 1'b1, BC, 1'b0);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            check("hold_receive", 32'(receive), 32'd1);
            check("hold_dout",    32'(dout),    32'hC3);
        end
        @(posedge clk); #1;
        check_frame("hold", 1'b0, BC, 8'hC3, 1'b0, 1'b0);

        // Load nonzero outputs, then reset during D4 of 8'hFF.
        send_frame(8'h3C, 1'b0, 1'b0, BC, 1'b0);
        check_frame("pre_rst", 1'b0, BC, 8'h3C, 1'b1, 1'b1);
        sin = 1'b0;
        repeat (BC) @(posedge clk);
        #1 sin = 1'b1;
        repeat (4 * BC + BC / 2) @(posedge clk);
        #1 Reset = 1'b1;
        @(posedge clk);
        #1 Reset = 1'b0;
        @(negedge clk);
        check("mid_rst_receive", 32'(receive), 32'd0);
        check("mid_rst_dout",    32'(dout),    32'h00);
        check("mid_rst_perr",    32'(perr),    32'd0);
        check("mid_rst_ferr",    32'(ferr),    32'd0);
        check("mid_rst_state",   32'(dut.r_state), 32'(IDLE));
        repeat (6 * BC) @(posedge clk);
        #1;
        send_frame(8'h5A, 1'b1, 1'b1, BC, 1'b0);
        check_frame("post_rst", 1'b0, BC, 8'h5A, 1'b0, 1'b0);

        // Back-to-back frames with Received tied high.
        received = 1'b1;
        mon_en   = 1'b1;
        send_frame(8'h12, 1'b1, 1'b1, BC, 1'b0);
        send_frame(8'h34, 1'b0, 1'b1, BC, 1'b0);
        repeat (2 * BC) @(posedge clk);
        #1 mon_en = 1'b0;
        received = 1'b0;
        check("b2b_pulses", 32'(pulses), 32'd2);
        check("b2b_dout0",  32'(cap[0]), 32'h12);
        check("b2b_dout1",  32'(cap[1]), 32'h34);
        check("b2b_width1", 32'(wide),   32'd0);

        // One frame at the default bit rate.
        send_frame(8'hA5, 1'b1, 1'b1, BCD, 1'b1);
        check_frame("def", 1'b1, BCD, 8'hA5, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
